// File: rtl/life_engine.sv
// Conway's Game of Life (B3/S23) engine on a toroidal WIDTH x HEIGHT grid.
// Holds the displayed generation in cur, builds the next one cell-by-cell
// into nxt, then commits it in a single cycle. Single-cell registered read port.
module life_engine #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int GEN_W  = 16,
    localparam int N     = WIDTH * HEIGHT,
    localparam int AW    = (N > 1) ? $clog2(N) : 1,
    localparam int PW    = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_valid,
    input  logic [N-1:0]     seed_data,
    input  logic             step,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] gen_count,
    output logic [PW-1:0]    population,
    input  logic [AW-1:0]    rd_addr,
    output logic             rd_cell
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        COMMIT
    } state_t;

    state_t        state;
    logic [N-1:0]  cur;
    logic [N-1:0]  nxt;
    logic [AW-1:0] idx;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    logic [XW-1:0] xm, xp;
    logic [YW-1:0] ym, yp;
    logic [AW-1:0] base_m, base_c, base_p;
    logic [7:0]    nb;
    logic [3:0]    ncount;
    logic          next_cell;

    function automatic logic [PW-1:0] popcount(input logic [N-1:0] g);
        logic [PW-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            c = c + PW'(g[i]);
        end
        return c;
    endfunction

    // Neighbourhood of the current scan cell; x/y counters avoid any modulo on idx
    always_comb begin
        xm = (x == '0) ? XW'(WIDTH - 1) : x - 1'b1;
        xp = (x == XW'(WIDTH - 1)) ? '0 : x + 1'b1;
        ym = (y == '0) ? YW'(HEIGHT - 1) : y - 1'b1;
        yp = (y == YW'(HEIGHT - 1)) ? '0 : y + 1'b1;

        base_m = AW'(ym) * AW'(WIDTH);
        base_c = AW'(y)  * AW'(WIDTH);
        base_p = AW'(yp) * AW'(WIDTH);

        nb = {cur[base_m + AW'(xm)], cur[base_m + AW'(x)], cur[base_m + AW'(xp)],
              cur[base_c + AW'(xm)],                       cur[base_c + AW'(xp)],
              cur[base_p + AW'(xm)], cur[base_p + AW'(x)], cur[base_p + AW'(xp)]};

        ncount = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            ncount = ncount + 4'(nb[k]);
        end

        next_cell = (ncount == 4'd3) || (cur[idx] && (ncount == 4'd2));
    end

    // Control FSM, grid buffers, counters and the registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur        <= '0;
            nxt        <= '0;
            idx        <= '0;
            x          <= '0;
            y          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            gen_count  <= '0;
            population <= '0;
            rd_cell    <= 1'b0;
        end else begin
            done    <= 1'b0;
            rd_cell <= ({1'b0, rd_addr} < (AW + 1)'(N)) ? cur[rd_addr] : 1'b0;

            case (state)
                IDLE: begin
                    if (seed_valid) begin
                        cur        <= seed_data;
                        population <= popcount(seed_data);
                        gen_count  <= '0;
                    end else if (step) begin
                        state <= COMPUTE;
                        busy  <= 1'b1;
                        idx   <= '0;
                        x     <= '0;
                        y     <= '0;
                    end
                end

                COMPUTE: begin
                    nxt[idx] <= next_cell;
                    if (idx == AW'(N - 1)) begin
                        state <= COMMIT;
                        idx   <= '0;
                        x     <= '0;
                        y     <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                        if (x == XW'(WIDTH - 1)) begin
                            x <= '0;
                            y <= y + 1'b1;
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end

                COMMIT: begin
                    cur        <= nxt;
                    population <= popcount(nxt);
                    gen_count  <= gen_count + 1'b1;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench for life_engine: directed scenarios plus random seeds,
// checked against a straightforward Game of Life reference model.
module tb_life_engine;

    localparam int N  = 64;
    localparam int ON = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_valid, step;
    logic [63:0] seed_data;
    logic [5:0]  rd_addr;
    logic        busy, done, rd_cell;
    logic [15:0] gen_count;
    logic [6:0]  population;

    logic        o_seed_valid, o_step;
    logic [14:0] o_seed_data;
    logic [3:0]  o_rd_addr;
    logic        o_busy, o_done, o_rd_cell;
    logic [15:0] o_gen;
    logic [3:0]  o_pop;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    logic [63:0] m_cur;
    int          m_gen;

    life_engine #(.WIDTH(8), .HEIGHT(8), .GEN_W(16)) u_dut (
        .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed_data(seed_data),
        .step(step), .busy(busy), .done(done), .gen_count(gen_count),
        .population(population), .rd_addr(rd_addr), .rd_cell(rd_cell)
    );

    // Non-power-of-two grid to exercise wrap-around and out-of-range reads
    life_engine #(.WIDTH(5), .HEIGHT(3), .GEN_W(16)) u_odd (
        .clk(clk), .rst(rst), .seed_valid(o_seed_valid), .seed_data(o_seed_data),
        .step(o_step), .busy(o_busy), .done(o_done), .gen_count(o_gen),
        .population(o_pop), .rd_addr(o_rd_addr), .rd_cell(o_rd_cell)
    );

    always #5 clk = ~clk;

    // Count done pulses of the 8x8 instance
    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: B3/S23 on a w x h torus, computed directly from the rules
    function automatic logic [63:0] life_next(input logic [63:0] g, input int w, input int h);
        logic [63:0] r;
        int cnt, nx, ny;
        r = '0;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                cnt = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (dx != 0 || dy != 0) begin
                            nx = (xx + dx + w) % w;
                            ny = (yy + dy + h) % h;
                            cnt += int'(g[ny * w + nx]);
                        end
                    end
                end
                r[yy * w + xx] = (cnt == 3) || (g[yy * w + xx] && cnt == 2);
            end
        end
        return r;
    endfunction

    task automatic load_seed(input logic [63:0] g);
        seed_valid = 1'b1;
        seed_data  = g;
        tick();
        seed_valid = 1'b0;
        m_cur = g;
        m_gen = 0;
        check("seed pop", 64'(population), 64'($countones(g)));
        check("seed gen", 64'(gen_count), 64'd0);
    endtask

    // done must appear N+1 edges after the edge that samples step
    task automatic do_step(input string tag);
        int e;
        step = 1'b1;
        tick();
        step = 1'b0;
        check({tag, " busy"}, 64'(busy), 64'd1);
        e = 0;
        while (!done && e < 200) begin
            tick();
            e++;
        end
        check({tag, " latency"}, 64'(e), 64'(N + 1));
        m_cur = life_next(m_cur, 8, 8);
        m_gen = (m_gen + 1) % 65536;
        check({tag, " gen"}, 64'(gen_count), 64'(m_gen));
        check({tag, " pop"}, 64'(population), 64'($countones(m_cur)));
        tick();
        check({tag, " done pulse"}, 64'(done), 64'd0);
    endtask

    task automatic read_grid(output logic [63:0] g);
        g = '0;
        for (int a = 0; a < N; a++) begin
            rd_addr = 6'(a);
            tick();
            g[a] = rd_cell;
        end
    endtask

    task automatic check_grid(input string tag);
        logic [63:0] g;
        read_grid(g);
        check(tag, g, m_cur);
    endtask

    logic [63:0] blinker, blinker_v, block, glider, g, og;
    int d0, e;

    initial begin
        blinker   = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
        blinker_v = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
        block     = (64'd1 << 27) | (64'd1 << 28) | (64'd1 << 35) | (64'd1 << 36);
        glider    = (64'd1 << 1) | (64'd1 << 10) | (64'd1 << 16) | (64'd1 << 17) | (64'd1 << 18);

        rst = 1'b1; seed_valid = 1'b0; step = 1'b0; seed_data = '0; rd_addr = '0;
        o_seed_valid = 1'b0; o_step = 1'b0; o_seed_data = '0; o_rd_addr = '0;
        tick(); tick();
        rst = 1'b0;
        m_cur = '0; m_gen = 0;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst gen", 64'(gen_count), 64'd0);
        check("rst pop", 64'(population), 64'd0);
        check("rst rd_cell", 64'(rd_cell), 64'd0);
        check_grid("rst grid");

        // Blinker oscillates with period 2
        load_seed(blinker);
        do_step("blink1");
        check_grid("blink1 grid");
        check("blink1 const", m_cur, blinker_v);
        do_step("blink2");
        check_grid("blink2 grid");
        check("blink2 gen", 64'(gen_count), 64'd2);

        // Block still life, five generations
        load_seed(block);
        d0 = done_cnt;
        for (int i = 0; i < 5; i++) do_step("block");
        check_grid("block grid");
        check("block const", m_cur, block);
        check("block gen", 64'(gen_count), 64'd5);
        check("block dones", 64'(done_cnt - d0), 64'd5);

        // Glider returns to its seed after 32 generations on 8x8
        load_seed(glider);
        for (int i = 0; i < 32; i++) begin
            do_step("glider");
            check("glider pop5", 64'(population), 64'd5);
        end
        check_grid("glider grid");
        check("glider const", m_cur, glider);

        // step mid-COMPUTE and seed during COMMIT are both ignored
        g = {$urandom, $urandom};
        load_seed(g);
        d0 = done_cnt;
        step = 1'b1;
        tick();
        step = 1'b0;
        e = 0;
        while (e < N) begin
            tick();
            e++;
            if (e == 10) step = 1'b1;
            if (e == 11) step = 1'b0;
        end
        seed_valid = 1'b1;
        seed_data  = ~g;
        tick();
        seed_valid = 1'b0;
        check("ign done", 64'(done), 64'd1);
        repeat (N + 5) tick();
        m_cur = life_next(g, 8, 8);
        check("ign dones", 64'(done_cnt - d0), 64'd1);
        check("ign gen", 64'(gen_count), 64'd1);
        check("ign busy", 64'(busy), 64'd0);
        check_grid("ign grid");

        // Reset while COMPUTE is at idx 20
        load_seed(blinker);
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort pop", 64'(population), 64'd0);
        check("abort gen", 64'(gen_count), 64'd0);
        m_cur = '0; m_gen = 0;
        check_grid("abort grid");
        load_seed(blinker);
        do_step("post-rst");
        check_grid("post-rst grid");
        check("post-rst const", m_cur, blinker_v);

        // Seed and step together: seed wins, no computation starts
        g = {$urandom, $urandom};
        seed_valid = 1'b1;
        step       = 1'b1;
        seed_data  = g;
        tick();
        seed_valid = 1'b0;
        step       = 1'b0;
        m_cur = g; m_gen = 0;
        repeat (3) begin
            check("both busy", 64'(busy), 64'd0);
            tick();
        end
        check("both gen", 64'(gen_count), 64'd0);
        check("both pop", 64'(population), 64'($countones(g)));
        check_grid("both grid");

        // Random seeds, several generations each
        for (int s = 0; s < 4; s++) begin
            load_seed({$urandom, $urandom});
            for (int i = 0; i < 3; i++) begin
                do_step("rand");
                check_grid("rand grid");
            end
        end

        // 5x3 instance: wrap on non-power-of-two dimensions
        for (int s = 0; s < 12; s++) begin
            og = 64'($urandom_range(0, 32767));
            o_seed_valid = 1'b1;
            o_seed_data  = og[14:0];
            tick();
            o_seed_valid = 1'b0;
            o_step = 1'b1;
            tick();
            o_step = 1'b0;
            e = 0;
            while (!o_done && e < 100) begin
                tick();
                e++;
            end
            check("odd latency", 64'(e), 64'(ON + 1));
            og = life_next(og, 5, 3);
            check("odd pop", 64'(o_pop), 64'($countones(og)));
            check("odd gen", 64'(o_gen), 64'd1);
            g = '0;
            for (int a = 0; a < ON; a++) begin
                o_rd_addr = 4'(a);
                tick();
                g[a] = o_rd_cell;
            end
            check("odd grid", g, og);
        end

        // Out-of-range read returns 0 even with every cell alive
        o_seed_valid = 1'b1;
        o_seed_data  = '1;
        tick();
        o_seed_valid = 1'b0;
        o_rd_addr = 4'd14;
        tick(); tick();
        check("odd rd in-range", 64'(o_rd_cell), 64'd1);
        o_rd_addr = 4'd15;
        tick(); tick();
        check("odd rd oob", 64'(o_rd_cell), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
